// File: rtl/rtc_pkg.sv
// Shared definitions for the rtc_clock command sequencer: command codes,
// field limits, operation/state encodings and the captured request payload.
package rtc_pkg;

  localparam int unsigned CMD_W   = 3;
  localparam int unsigned DATA_W  = 10;
  localparam int unsigned HOURS_W = 5;
  localparam int unsigned MIN_W   = 6;
  localparam int unsigned SEC_W   = 6;
  localparam int unsigned MS_W    = 10;

  localparam logic [CMD_W-1:0] CMD_SET_HOURS        = 3'b111;
  localparam logic [CMD_W-1:0] CMD_SET_MINUTES      = 3'b110;
  localparam logic [CMD_W-1:0] CMD_SET_SECONDS      = 3'b101;
  localparam logic [CMD_W-1:0] CMD_SET_MILLISECONDS = 3'b011;
  localparam logic [CMD_W-1:0] CMD_RESET_TIME       = 3'b010;

  localparam int unsigned HOURS_MAX   = 24;
  localparam int unsigned MINUTES_MAX = 60;
  localparam int unsigned SECONDS_MAX = 60;
  localparam int unsigned MS_MAX      = 1000;

  typedef enum logic {
    OP_LOAD  = 1'b0,
    OP_CLEAR = 1'b1
  } rtc_op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CLR  = 3'd1,
    ST_HRS  = 3'd2,
    ST_MIN  = 3'd3,
    ST_SEC  = 3'd4,
    ST_MS   = 3'd5
  } rtc_state_e;

  typedef struct packed {
    rtc_op_e              op;
    logic [HOURS_W-1:0]   hours;
    logic [MIN_W-1:0]     minutes;
    logic [SEC_W-1:0]     seconds;
    logic [MS_W-1:0]      ms;
  } rtc_req_t;

  // True when every time field of a LOAD is a legal clock value.
  function automatic logic req_in_range(input rtc_req_t r);
    return (r.hours   < HOURS_W'(HOURS_MAX))   &&
           (r.minutes < MIN_W'(MINUTES_MAX))   &&
           (r.seconds < SEC_W'(SECONDS_MAX))   &&
           (r.ms      < MS_W'(MS_MAX));
  endfunction

endpackage

// File: rtl/rtc_set_sequencer_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, searching from the
// requester after the last accepted one; pointer moves only on acceptance.
module rr_arbiter #(
  parameter int unsigned N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         upd,
  output logic [N-1:0] grant_c
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] last_q;
  logic [PW-1:0] win_c;
  logic [PW-1:0] idx_c;
  logic          found_c;

  // First asserted request at offset 1..N from the last grant wins.
  always_comb begin
    grant_c = '0;
    win_c   = last_q;
    idx_c   = '0;
    found_c = 1'b0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx_c = PW'((32'(last_q) + k) % N);
      if (!found_c && req[idx_c]) begin
        found_c        = 1'b1;
        grant_c[idx_c] = 1'b1;
        win_c          = idx_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= PW'(N - 1);
    end else if (upd) begin
      last_q <= win_c;
    end
  end

endmodule

// File: rtl/rtc_set_sequencer.sv
// Arbitrates NUM_REQ requesters onto the rtc_clock command port and expands
// each accepted LOAD/CLEAR into a burst of single-cycle commands.
module rtc_set_sequencer
  import rtc_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_n_i,
  input  logic [NUM_REQ-1:0]                req_valid_i,
  output logic [NUM_REQ-1:0]                req_ready_o,
  input  logic [NUM_REQ-1:0]                req_op_i,
  input  logic [NUM_REQ-1:0][HOURS_W-1:0]   req_hours_i,
  input  logic [NUM_REQ-1:0][MIN_W-1:0]     req_minutes_i,
  input  logic [NUM_REQ-1:0][SEC_W-1:0]     req_seconds_i,
  input  logic [NUM_REQ-1:0][MS_W-1:0]      req_ms_i,
  output logic [NUM_REQ-1:0]                done_o,
  output logic [NUM_REQ-1:0]                err_o,
  output logic                              cmd_valid_o,
  output logic [CMD_W-1:0]                  cmd_type_o,
  output logic [DATA_W-1:0]                 cmd_data_o
);

  rtc_state_e          state_q, state_d;
  rtc_req_t            cap_q, cap_d, sel_c;
  logic [NUM_REQ-1:0]  owner_q, owner_d;
  logic [NUM_REQ-1:0]  grant_c;
  logic [NUM_REQ-1:0]  done_d, err_d;
  logic                accept_c;
  logic                cmd_valid_d;
  logic [CMD_W-1:0]    cmd_type_d;
  logic [DATA_W-1:0]   cmd_data_d;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk     (clk_i),
    .rst_n   (rst_n_i),
    .req     (req_valid_i),
    .upd     (accept_c),
    .grant_c (grant_c)
  );

  assign req_ready_o = (state_q == ST_IDLE) ? grant_c : '0;
  assign accept_c    = |(req_valid_i & req_ready_o);

  // Fields of the current winner, ready to be captured on acceptance.
  always_comb begin
    sel_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_c[i]) begin
        sel_c.op      = rtc_op_e'(req_op_i[i]);
        sel_c.hours   = req_hours_i[i];
        sel_c.minutes = req_minutes_i[i];
        sel_c.seconds = req_seconds_i[i];
        sel_c.ms      = req_ms_i[i];
      end
    end
  end

  // Next state plus the values the output registers take on this edge.
  always_comb begin
    state_d     = state_q;
    cap_d       = cap_q;
    owner_d     = owner_q;
    done_d      = '0;
    err_d       = '0;
    cmd_valid_d = 1'b0;
    cmd_type_d  = '0;
    cmd_data_d  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          cap_d   = sel_c;
          owner_d = req_ready_o;
          if ((sel_c.op == OP_LOAD) && !req_in_range(sel_c)) begin
            done_d = req_ready_o;
            err_d  = req_ready_o;
          end else begin
            state_d     = ST_CLR;
            cmd_valid_d = 1'b1;
            cmd_type_d  = CMD_RESET_TIME;
          end
        end
      end
      ST_CLR: begin
        if (cap_q.op == OP_CLEAR) begin
          state_d = ST_IDLE;
          done_d  = owner_q;
        end else begin
          state_d     = ST_HRS;
          cmd_valid_d = 1'b1;
          cmd_type_d  = CMD_SET_HOURS;
          cmd_data_d  = DATA_W'(cap_q.hours);
        end
      end
      ST_HRS: begin
        state_d     = ST_MIN;
        cmd_valid_d = 1'b1;
        cmd_type_d  = CMD_SET_MINUTES;
        cmd_data_d  = DATA_W'(cap_q.minutes);
      end
      ST_MIN: begin
        state_d     = ST_SEC;
        cmd_valid_d = 1'b1;
        cmd_type_d  = CMD_SET_SECONDS;
        cmd_data_d  = DATA_W'(cap_q.seconds);
      end
      // Milliseconds written last so the loaded value is exact.
      ST_SEC: begin
        state_d     = ST_MS;
        cmd_valid_d = 1'b1;
        cmd_type_d  = CMD_SET_MILLISECONDS;
        cmd_data_d  = DATA_W'(cap_q.ms);
      end
      ST_MS: begin
        state_d = ST_IDLE;
        done_d  = owner_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      cap_q       <= '0;
      owner_q     <= '0;
      done_o      <= '0;
      err_o       <= '0;
      cmd_valid_o <= 1'b0;
      cmd_type_o  <= '0;
      cmd_data_o  <= '0;
    end else begin
      state_q     <= state_d;
      cap_q       <= cap_d;
      owner_q     <= owner_d;
      done_o      <= done_d;
      err_o       <= err_d;
      cmd_valid_o <= cmd_valid_d;
      cmd_type_o  <= cmd_type_d;
      cmd_data_o  <= cmd_data_d;
    end
  end

endmodule

// File: tb/tb_rtc_set_sequencer.sv
// Directed bench for rtc_set_sequencer: expected commands and completions are
// queued with their due cycle as stimulus is driven and checked as they appear.
module tb_rtc_set_sequencer;

  localparam logic [2:0] C_HRS = 3'b111;
  localparam logic [2:0] C_MIN = 3'b110;
  localparam logic [2:0] C_SEC = 3'b101;
  localparam logic [2:0] C_MS  = 3'b011;
  localparam logic [2:0] C_RST = 3'b010;

  typedef struct {
    int         cyc;
    logic [2:0] typ;
    logic [9:0] data;
  } cmd_exp_t;

  typedef struct {
    int         cyc;
    logic [1:0] done;
    logic [1:0] err;
  } done_exp_t;

  logic            clk = 1'b0;
  logic            rst_n_i = 1'b0;
  logic [1:0]      req_valid_i = '0;
  logic [1:0]      req_ready_o;
  logic [1:0]      req_op_i = '0;
  logic [1:0][4:0] req_hours_i = '0;
  logic [1:0][5:0] req_minutes_i = '0;
  logic [1:0][5:0] req_seconds_i = '0;
  logic [1:0][9:0] req_ms_i = '0;
  logic [1:0]      done_o;
  logic [1:0]      err_o;
  logic            cmd_valid_o;
  logic [2:0]      cmd_type_o;
  logic [9:0]      cmd_data_o;

  int        cyc = 0;
  int        errors = 0;
  int        checks = 0;
  cmd_exp_t  cmd_q[$];
  done_exp_t done_q[$];
  cmd_exp_t  mon_ce;
  done_exp_t mon_de;

  logic [4:0] m_h = '0;
  logic [5:0] m_m = '0;
  logic [5:0] m_s = '0;
  logic [9:0] m_ms = '0;

  rtc_set_sequencer #(.NUM_REQ(2)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n_i),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_op_i      (req_op_i),
    .req_hours_i   (req_hours_i),
    .req_minutes_i (req_minutes_i),
    .req_seconds_i (req_seconds_i),
    .req_ms_i      (req_ms_i),
    .done_o        (done_o),
    .err_o         (err_o),
    .cmd_valid_o   (cmd_valid_o),
    .cmd_type_o    (cmd_type_o),
    .cmd_data_o    (cmd_data_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Downstream rtc_clock model: commands override, otherwise ms ticks each cycle.
  always @(posedge clk) begin
    if (cmd_valid_o) begin
      case (cmd_type_o)
        C_RST: begin m_h <= '0; m_m <= '0; m_s <= '0; m_ms <= '0; end
        C_HRS: m_h  <= cmd_data_o[4:0];
        C_MIN: m_m  <= cmd_data_o[5:0];
        C_SEC: m_s  <= cmd_data_o[5:0];
        C_MS:  m_ms <= cmd_data_o;
        default: ;
      endcase
    end else if (m_ms == 10'd999) begin
      m_ms <= '0;
      m_s  <= (m_s == 6'd59) ? 6'd0 : m_s + 6'd1;
    end else begin
      m_ms <= m_ms + 10'd1;
    end
  end

  // Scoreboard side: every DUT output event must match the head of its queue.
  always @(negedge clk) begin
    check("ready_onehot0", 32'($onehot0(req_ready_o)), 32'd1);
    if (cmd_valid_o) begin
      check("cmd_expected", 32'(cmd_q.size() != 0), 32'd1);
      if (cmd_q.size() != 0) begin
        mon_ce = cmd_q.pop_front();
        check("cmd_cycle", 32'(cyc), 32'(mon_ce.cyc));
        check("cmd_type", 32'(cmd_type_o), 32'(mon_ce.typ));
        check("cmd_data", 32'(cmd_data_o), 32'(mon_ce.data));
      end
    end else begin
      check("cmd_quiet", 32'({cmd_type_o, cmd_data_o}), 32'd0);
    end
    if (cmd_q.size() != 0 && cmd_q[0].cyc < cyc) begin
      check("cmd_missing_cycle", 32'(cyc), 32'(cmd_q[0].cyc));
      mon_ce = cmd_q.pop_front();
    end
    if (done_o != 2'b00 || err_o != 2'b00) begin
      check("done_expected", 32'(done_q.size() != 0), 32'd1);
      if (done_q.size() != 0) begin
        mon_de = done_q.pop_front();
        check("done_cycle", 32'(cyc), 32'(mon_de.cyc));
        check("done_vec", 32'(done_o), 32'(mon_de.done));
        check("err_vec", 32'(err_o), 32'(mon_de.err));
      end
    end
    if (done_q.size() != 0 && done_q[0].cyc < cyc) begin
      check("done_missing_cycle", 32'(cyc), 32'(done_q[0].cyc));
      mon_de = done_q.pop_front();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int n);
    while (cyc < n) step();
  endtask

  task automatic set_req(input int i, input logic op, input int h, input int m,
                         input int s, input int ms);
    req_op_i[i]      = op;
    req_hours_i[i]   = 5'(h);
    req_minutes_i[i] = 6'(m);
    req_seconds_i[i] = 6'(s);
    req_ms_i[i]      = 10'(ms);
  endtask

  task automatic push_load(input int t, input int ow, input int h, input int m,
                           input int s, input int ms);
    cmd_q.push_back('{t + 1, C_RST, 10'd0});
    cmd_q.push_back('{t + 2, C_HRS, 10'(h)});
    cmd_q.push_back('{t + 3, C_MIN, 10'(m)});
    cmd_q.push_back('{t + 4, C_SEC, 10'(s)});
    cmd_q.push_back('{t + 5, C_MS,  10'(ms)});
    done_q.push_back('{t + 6, 2'(1 << ow), 2'b00});
  endtask

  task automatic push_clear(input int t, input int ow);
    cmd_q.push_back('{t + 1, C_RST, 10'd0});
    done_q.push_back('{t + 2, 2'(1 << ow), 2'b00});
  endtask

  task automatic push_reject(input int t, input int ow);
    done_q.push_back('{t + 1, 2'(1 << ow), 2'(1 << ow)});
  endtask

  task automatic check_ready(input string tag, input logic [1:0] exp);
    @(negedge clk);
    check(tag, 32'(req_ready_o), 32'(exp));
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t, t0, c, d, e, f;
    // Reset values; ready follows valid with requester 0 first.
    @(negedge clk);
    check("rst_cmd_valid", 32'(cmd_valid_o), 32'd0);
    check("rst_cmd_bus", 32'({cmd_type_o, cmd_data_o}), 32'd0);
    check("rst_done_err", 32'({done_o, err_o}), 32'd0);
    check("rst_ready_idle", 32'(req_ready_o), 32'd0);
    req_valid_i = 2'b10;
    #1 check("rst_ready_only1", 32'(req_ready_o), 32'b10);
    req_valid_i = 2'b11;
    #1 check("rst_ready_both", 32'(req_ready_o), 32'b01);
    req_valid_i = 2'b00;
    step();
    rst_n_i = 1'b1;
    step();

    // LOAD 13:45:30.500 from requester 0, then fields are trashed.
    t = cyc;
    set_req(0, 1'b0, 13, 45, 30, 500);
    req_valid_i = 2'b01;
    push_load(t, 0, 13, 45, 30, 500);
    check_ready("load0_ready", 2'b01);
    step();
    req_valid_i = 2'b00;
    set_req(0, 1'b0, 31, 63, 63, 1023);
    goto(t + 6);
    @(negedge clk);
    check("rtc_loaded", 32'({m_h, m_m, m_s, m_ms}), 32'({5'd13, 6'd45, 6'd30, 10'd500}));
    step();
    @(negedge clk);
    check("rtc_ticked", 32'({m_h, m_m, m_s, m_ms}), 32'({5'd13, 6'd45, 6'd30, 10'd501}));
    step();

    // Both requesters hold LOAD: grants alternate every 6 cycles.
    t0 = cyc;
    set_req(0, 1'b0, 1, 2, 3, 4);
    set_req(1, 1'b0, 23, 59, 59, 999);
    req_valid_i = 2'b11;
    for (int g = 0; g < 4; g++) begin
      if (g % 2 == 0) push_load(t0 + 6 * g, 1, 23, 59, 59, 999);
      else            push_load(t0 + 6 * g, 0, 1, 2, 3, 4);
    end
    for (int g = 0; g < 4; g++) begin
      goto(t0 + 6 * g);
      check_ready("alt_grant", (g % 2 == 0) ? 2'b10 : 2'b01);
      if (g == 0) begin
        goto(t0 + 3);
        check_ready("busy_ready", 2'b00);
      end
    end
    step();
    req_valid_i = 2'b00;
    goto(t0 + 24);

    // Out-of-range hours, then out-of-range ms, then a valid request at once.
    c = cyc;
    set_req(1, 1'b0, 24, 0, 0, 0);
    req_valid_i = 2'b10;
    push_reject(c, 1);
    check_ready("rej_hours_ready", 2'b10);
    step();
    set_req(1, 1'b0, 0, 0, 0, 1000);
    push_reject(c + 1, 1);
    check_ready("rej_ms_ready", 2'b10);
    step();
    req_valid_i = 2'b01;
    set_req(0, 1'b0, 0, 0, 0, 999);
    push_load(c + 2, 0, 0, 0, 0, 999);
    check_ready("after_rej_ready", 2'b01);
    step();
    req_valid_i = 2'b00;
    goto(c + 8);

    // CLEAR ignores field ranges; next LOAD accepted in the done cycle.
    d = cyc;
    set_req(1, 1'b1, 31, 63, 63, 1023);
    req_valid_i = 2'b10;
    push_clear(d, 1);
    check_ready("clear_ready", 2'b10);
    step();
    req_valid_i = 2'b00;
    check_ready("clear_busy", 2'b00);
    step();
    set_req(0, 1'b0, 5, 6, 7, 8);
    req_valid_i = 2'b01;
    push_load(d + 2, 0, 5, 6, 7, 8);
    check_ready("post_clear_ready", 2'b01);
    step();
    req_valid_i = 2'b00;
    set_req(0, 1'b0, 0, 0, 0, 0);

    // Asynchronous reset during the SET_MINUTES cycle.
    goto(d + 5);
    check("mid_min_valid", 32'(cmd_valid_o), 32'd1);
    check("mid_min_cmd", 32'({cmd_type_o, cmd_data_o}), 32'({C_MIN, 10'd6}));
    cmd_q.delete();
    done_q.delete();
    rst_n_i = 1'b0;
    #1;
    check("async_rst_valid", 32'(cmd_valid_o), 32'd0);
    check("async_rst_bus", 32'({cmd_type_o, cmd_data_o, done_o, err_o}), 32'd0);
    step();
    step();
    rst_n_i = 1'b1;
    e = cyc;
    set_req(0, 1'b0, 9, 10, 11, 12);
    set_req(1, 1'b0, 20, 30, 40, 50);
    req_valid_i = 2'b11;
    push_load(e, 0, 9, 10, 11, 12);
    check_ready("post_rst_ready", 2'b01);
    step();
    req_valid_i = 2'b00;
    goto(e + 6);

    // Requester 0 withdraws while requester 1 is busy; pointer must not move.
    f = cyc;
    set_req(1, 1'b0, 12, 0, 0, 0);
    req_valid_i = 2'b10;
    push_load(f, 1, 12, 0, 0, 0);
    check_ready("busy1_ready", 2'b10);
    step();
    req_valid_i = 2'b11;
    check_ready("cancel_not_ready", 2'b00);
    goto(f + 3);
    req_valid_i = 2'b00;
    goto(f + 6);
    set_req(0, 1'b0, 1, 1, 1, 1);
    set_req(1, 1'b0, 2, 2, 2, 2);
    req_valid_i = 2'b11;
    push_load(f + 6, 0, 1, 1, 1, 1);
    check_ready("cancel_ptr_ready", 2'b01);
    step();
    req_valid_i = 2'b00;
    goto(f + 14);

    check("cmd_q_drained", 32'(cmd_q.size()), 32'd0);
    check("done_q_drained", 32'(done_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
